// File: rtl/seat_pkg.sv
// Shared seat-table definitions used by both the read and write paths.
package seat_pkg;

  localparam int unsigned NUM_SEATS = 32;
  localparam int unsigned SEAT_W    = 5;
  localparam int unsigned TIME_W    = 11;
  localparam int unsigned STUDENT_W = 32;

  typedef enum logic [1:0] {
    SeatEmpty    = 2'b00,
    SeatSeated   = 2'b01,
    SeatAway     = 2'b10,
    SeatReserved = 2'b11
  } seat_state_t;

  typedef enum logic {
    OpLookup   = 1'b0,
    OpFindFree = 1'b1
  } req_op_t;

endpackage

// File: rtl/seat_elapsed_calc.sv
// Elapsed time since a seat's last write, plus the away-too-long check.
// Pure combinational; the timer is free-running so the subtraction wraps.
module seat_elapsed_calc
  import seat_pkg::*;
(
  input  logic [TIME_W-1:0] now_i,
  input  logic [TIME_W-1:0] stamp_i,
  input  logic [TIME_W-1:0] limit_i,
  input  logic              away_i,
  output logic [TIME_W-1:0] elapsed_o,
  output logic              overtime_o
);

  // Modular difference; overtime only when strictly past the limit.
  always_comb begin
    elapsed_o  = now_i - stamp_i;
    overtime_o = away_i && (elapsed_o > limit_i);
  end

endmodule

// File: rtl/seat_status_reader.sv
// Read-side responder for the seat record memory: single-seat lookup and
// first-free-seat scan over a synchronous read port. Never writes records.
module seat_status_reader
  import seat_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic [SEAT_W-1:0]    req_seat,
  input  logic [TIME_W-1:0]    now_time,
  input  logic [TIME_W-1:0]    limit_time,
  output logic                 mem_rd_en,
  output logic [SEAT_W-1:0]    mem_rd_addr,
  input  logic [STUDENT_W-1:0] mem_rd_student,
  input  logic [1:0]           mem_rd_state,
  input  logic [TIME_W-1:0]    mem_rd_stamp,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [SEAT_W-1:0]    rsp_seat,
  output logic [STUDENT_W-1:0] rsp_student,
  output logic [1:0]           rsp_state,
  output logic [TIME_W-1:0]    rsp_elapsed,
  output logic                 rsp_found,
  output logic                 rsp_overtime
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StScan,
    StCheck,
    StResp
  } reader_state_t;

  localparam logic [SEAT_W:0]   NumSeatsW = (SEAT_W+1)'(NUM_SEATS);
  localparam logic [SEAT_W:0]   CntOne    = (SEAT_W+1)'(1);
  localparam logic [SEAT_W-1:0] LastSeat  = SEAT_W'(NUM_SEATS - 1);

  reader_state_t        state_q;
  logic                 req_ready_q;
  logic [SEAT_W-1:0]    req_seat_q;
  logic                 seat_bad_q;
  // Scan counter holds the address issued this cycle; data on the read port
  // belongs to cnt_q - 1. Extra bit lets it reach NUM_SEATS for the final
  // data-only cycle.
  logic [SEAT_W:0]      cnt_q;
  logic                 mem_rd_en_q;
  logic [SEAT_W-1:0]    mem_rd_addr_q;
  logic                 rsp_valid_q;
  logic [SEAT_W-1:0]    rsp_seat_q;
  logic [STUDENT_W-1:0] rsp_student_q;
  logic [1:0]           rsp_state_q;
  logic [TIME_W-1:0]    rsp_elapsed_q;
  logic                 rsp_found_q;
  logic                 rsp_overtime_q;

  seat_state_t          rd_state;
  logic                 rd_empty;
  logic [TIME_W-1:0]    calc_elapsed;
  logic                 calc_overtime;
  logic [TIME_W-1:0]    rec_elapsed;
  logic [SEAT_W:0]      cnt_inc;
  logic [SEAT_W:0]      cnt_dec;
  logic                 scan_hit;
  logic                 req_bad;

  seat_elapsed_calc u_elapsed_calc (
    .now_i      (now_time),
    .stamp_i    (mem_rd_stamp),
    .limit_i    (limit_time),
    .away_i     (rd_state == SeatAway),
    .elapsed_o  (calc_elapsed),
    .overtime_o (calc_overtime)
  );

  // Decode the record currently on the read port and scan bookkeeping.
  always_comb begin
    rd_state    = seat_state_t'(mem_rd_state);
    rd_empty    = (rd_state == SeatEmpty);
    rec_elapsed = rd_empty ? '0 : calc_elapsed;
    cnt_inc     = cnt_q + CntOne;
    cnt_dec     = cnt_q - CntOne;
    // First scan cycle has no data yet, so it can never hit.
    scan_hit    = (cnt_q != '0) && rd_empty;
    req_bad     = ({1'b0, req_seat} >= NumSeatsW);
  end

  // Request/response FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      req_ready_q    <= 1'b1;
      req_seat_q     <= '0;
      seat_bad_q     <= 1'b0;
      cnt_q          <= '0;
      mem_rd_en_q    <= 1'b0;
      mem_rd_addr_q  <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_seat_q     <= '0;
      rsp_student_q  <= '0;
      rsp_state_q    <= '0;
      rsp_elapsed_q  <= '0;
      rsp_found_q    <= 1'b0;
      rsp_overtime_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            req_seat_q  <= req_seat;
            if (req_op == OpFindFree) begin
              state_q       <= StScan;
              cnt_q         <= '0;
              mem_rd_en_q   <= 1'b1;
              mem_rd_addr_q <= '0;
            end else begin
              state_q       <= StRead;
              seat_bad_q    <= req_bad;
              mem_rd_en_q   <= !req_bad;
              mem_rd_addr_q <= req_seat;
            end
          end
        end

        StRead: begin
          mem_rd_en_q <= 1'b0;
          state_q     <= StCheck;
        end

        StCheck: begin
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
          if (seat_bad_q) begin
            // Out-of-range seat: no read was issued, answer with all zeros.
            rsp_seat_q     <= '0;
            rsp_student_q  <= '0;
            rsp_state_q    <= '0;
            rsp_elapsed_q  <= '0;
            rsp_found_q    <= 1'b0;
            rsp_overtime_q <= 1'b0;
          end else begin
            rsp_seat_q     <= req_seat_q;
            rsp_student_q  <= mem_rd_student;
            rsp_state_q    <= mem_rd_state;
            rsp_elapsed_q  <= rec_elapsed;
            rsp_found_q    <= !rd_empty;
            rsp_overtime_q <= calc_overtime;
          end
        end

        StScan: begin
          if (scan_hit || (cnt_q == NumSeatsW)) begin
            // Either a free seat or the last record; any read still in
            // flight is simply dropped.
            rsp_valid_q    <= 1'b1;
            mem_rd_en_q    <= 1'b0;
            state_q        <= StResp;
            rsp_seat_q     <= scan_hit ? cnt_dec[SEAT_W-1:0] : LastSeat;
            rsp_found_q    <= scan_hit;
            rsp_student_q  <= mem_rd_student;
            rsp_state_q    <= mem_rd_state;
            rsp_elapsed_q  <= rec_elapsed;
            rsp_overtime_q <= calc_overtime;
          end else begin
            cnt_q         <= cnt_inc;
            mem_rd_en_q   <= (cnt_inc < NumSeatsW);
            mem_rd_addr_q <= cnt_inc[SEAT_W-1:0];
          end
        end

        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end

        default: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          mem_rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign mem_rd_en    = mem_rd_en_q;
  assign mem_rd_addr  = mem_rd_addr_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_seat     = rsp_seat_q;
  assign rsp_student  = rsp_student_q;
  assign rsp_state    = rsp_state_q;
  assign rsp_elapsed  = rsp_elapsed_q;
  assign rsp_found    = rsp_found_q;
  assign rsp_overtime = rsp_overtime_q;

endmodule

// File: tb/tb_seat_status_reader.sv
// Scoreboard bench for seat_status_reader: directed requests push expected
// responses; a monitor pops and compares whenever a response appears.
module tb_seat_status_reader;
  import seat_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic                 req_op = 1'b0;
  logic [SEAT_W-1:0]    req_seat = '0;
  logic [TIME_W-1:0]    now_time = '0;
  logic [TIME_W-1:0]    limit_time = '0;
  logic                 mem_rd_en;
  logic [SEAT_W-1:0]    mem_rd_addr;
  logic [STUDENT_W-1:0] mem_rd_student = '0;
  logic [1:0]           mem_rd_state = '0;
  logic [TIME_W-1:0]    mem_rd_stamp = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [SEAT_W-1:0]    rsp_seat;
  logic [STUDENT_W-1:0] rsp_student;
  logic [1:0]           rsp_state;
  logic [TIME_W-1:0]    rsp_elapsed;
  logic                 rsp_found;
  logic                 rsp_overtime;

  seat_status_reader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_seat       (req_seat),
    .now_time       (now_time),
    .limit_time     (limit_time),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_student (mem_rd_student),
    .mem_rd_state   (mem_rd_state),
    .mem_rd_stamp   (mem_rd_stamp),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_seat       (rsp_seat),
    .rsp_student    (rsp_student),
    .rsp_state      (rsp_state),
    .rsp_elapsed    (rsp_elapsed),
    .rsp_found      (rsp_found),
    .rsp_overtime   (rsp_overtime)
  );

  always #5 clk = ~clk;

  // Seat memory model with a synchronous read port.
  logic [STUDENT_W-1:0] m_student [NUM_SEATS];
  logic [1:0]           m_state   [NUM_SEATS];
  logic [TIME_W-1:0]    m_stamp   [NUM_SEATS];

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_student <= m_student[mem_rd_addr];
      mem_rd_state   <= m_state[mem_rd_addr];
      mem_rd_stamp   <= m_stamp[mem_rd_addr];
    end
  end

  int cyc = 0;
  int rd_total = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) rd_total <= rd_total + 1;
  end

  typedef struct {
    logic [SEAT_W-1:0]    seat;
    logic [STUDENT_W-1:0] student;
    logic [1:0]           state;
    logic [TIME_W-1:0]    elapsed;
    logic                 found;
    logic                 overtime;
    int                   rise;
    int                   reads;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   have_cur = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_e0 = 0;
  int   last_acc = 0;
  int   rd_base = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [SEAT_W-1:0] seat, input logic [STUDENT_W-1:0] stu,
                              input logic [1:0] st, input logic [TIME_W-1:0] el,
                              input logic fd, input logic ot, input int reads);
    exp_t e;
    e.seat = seat; e.student = stu; e.state = st; e.elapsed = el;
    e.found = fd; e.overtime = ot; e.rise = 0; e.reads = reads;
    return e;
  endfunction

  // Present a request, wait (bounded) for acceptance, queue the expectation.
  task automatic issue(input logic op, input logic [SEAT_W-1:0] seat, input exp_t e,
                       input int lat, input bit push);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_seat  = seat;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_accept_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    last_e0 = cyc + 1;
    if (push) begin
      e.rise = last_e0 + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  // Monitor: compares each new response against the scoreboard and checks
  // that held responses stay put and the handshake releases correctly.
  initial begin
    bit prev_v = 0;
    bit acc_pend = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v   = 0;
        acc_pend = 0;
        have_cur = 0;
        rd_base  = rd_total;
      end else begin
        if (acc_pend) begin
          chk("post_accept_valid", 64'(rsp_valid), 64'd0);
          chk("post_accept_ready", 64'(req_ready), 64'd1);
          acc_pend = 0;
        end
        if (rsp_valid) begin
          chk("busy_req_ready", 64'(req_ready), 64'd0);
          if (!prev_v) begin
            if (sb.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_rsp: got seat %0d expected no response", rsp_seat);
            end else begin
              cur = sb.pop_front();
              have_cur = 1;
              chk("rsp_rise_cycle", 64'(cyc), 64'(cur.rise));
              chk("rsp_seat", 64'(rsp_seat), 64'(cur.seat));
              chk("rsp_student", 64'(rsp_student), 64'(cur.student));
              chk("rsp_state", 64'(rsp_state), 64'(cur.state));
              chk("rsp_elapsed", 64'(rsp_elapsed), 64'(cur.elapsed));
              chk("rsp_found", 64'(rsp_found), 64'(cur.found));
              chk("rsp_overtime", 64'(rsp_overtime), 64'(cur.overtime));
              chk("mem_read_count", 64'(rd_total - rd_base), 64'(cur.reads));
              rd_base = rd_total;
            end
          end else if (have_cur) begin
            chk("hold_seat", 64'(rsp_seat), 64'(cur.seat));
            chk("hold_student", 64'(rsp_student), 64'(cur.student));
            chk("hold_elapsed", 64'(rsp_elapsed), 64'(cur.elapsed));
            chk("hold_overtime", 64'(rsp_overtime), 64'(cur.overtime));
          end
          if (rsp_ready) begin
            acc_pend = 1;
            last_acc = cyc + 1;
          end
        end
        prev_v = rsp_valid;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    for (int i = 0; i < int'(NUM_SEATS); i++) begin
      m_student[i] = 32'h1000_0000 + i;
      m_state[i]   = 2'b01;
      m_stamp[i]   = TIME_W'(i * 10);
    end
    m_student[3]  = 32'h1234_ABCD; m_state[3]  = 2'b01; m_stamp[3]  = 11'd100;
    m_student[5]  = 32'h0000_0055; m_state[5]  = 2'b10; m_stamp[5]  = 11'd2040;
    m_student[7]  = 32'h0000_0077; m_state[7]  = 2'b00; m_stamp[7]  = 11'd0;
    m_student[10] = 32'hDEAD_0001; m_state[10] = 2'b00; m_stamp[10] = 11'd5;
    m_student[31] = 32'h1000_001F; m_state[31] = 2'b10; m_stamp[31] = 11'd310;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_mem_rd_en", 64'(mem_rd_en), 64'd0);
    chk("reset_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
    chk("reset_rsp_student", 64'(rsp_student), 64'd0);
    chk("reset_rsp_found", 64'(rsp_found), 64'd0);
    #2 rst_n = 1'b1;

    // LOOKUP seated seat 3: elapsed 150-100
    now_time = 11'd150; limit_time = 11'd20;
    e = mk(5'd3, 32'h1234_ABCD, 2'b01, 11'd50, 1'b1, 1'b0, 1);
    issue(1'b0, 5'd3, e, 2, 1'b1);
    drain();

    // LOOKUP away seat 5 with wrap: (20-2040) mod 2048 = 28
    now_time = 11'd20; limit_time = 11'd20;
    e = mk(5'd5, 32'h0000_0055, 2'b10, 11'd28, 1'b1, 1'b1, 1);
    issue(1'b0, 5'd5, e, 2, 1'b1);
    drain();
    limit_time = 11'd28;
    e = mk(5'd5, 32'h0000_0055, 2'b10, 11'd28, 1'b1, 1'b0, 1);
    issue(1'b0, 5'd5, e, 2, 1'b1);
    drain();

    // LOOKUP empty seat 10: not found, elapsed forced to 0
    now_time = 11'd500; limit_time = 11'd20;
    e = mk(5'd10, 32'hDEAD_0001, 2'b00, 11'd0, 1'b0, 1'b0, 1);
    issue(1'b0, 5'd10, e, 2, 1'b1);
    drain();

    // FIND_FREE: seats 0-6 occupied, seat 7 empty -> E9, reads 0..8
    e = mk(5'd7, 32'h0000_0077, 2'b00, 11'd0, 1'b1, 1'b0, 9);
    issue(1'b1, 5'd0, e, 9, 1'b1);
    drain();

    // FIND_FREE with every seat occupied -> seat 31 record, E33
    m_state[7] = 2'b11; m_state[10] = 2'b01;
    now_time = 11'd1000; limit_time = 11'd600;
    e = mk(5'd31, 32'h1000_001F, 2'b10, 11'd690, 1'b0, 1'b1, 32);
    issue(1'b1, 5'd0, e, 33, 1'b1);
    drain();

    // Back-pressure: response held 5 cycles, next request waits for release
    now_time = 11'd150; limit_time = 11'd20;
    rsp_ready = 1'b0;
    e = mk(5'd3, 32'h1234_ABCD, 2'b01, 11'd50, 1'b1, 1'b0, 1);
    issue(1'b0, 5'd3, e, 2, 1'b1);
    fork
      begin
        exp_t e2;
        e2 = mk(5'd5, 32'h0000_0055, 2'b10, 11'd158, 1'b1, 1'b1, 1);
        issue(1'b0, 5'd5, e2, 2, 1'b1);
        chk("accept_after_release", 64'(last_e0), 64'(last_acc + 1));
      end
      begin
        n = 0;
        while (!rsp_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a scan: nothing may come back
    e = mk(5'd0, 32'h0, 2'b00, 11'd0, 1'b0, 1'b0, 0);
    issue(1'b1, 5'd0, e, 0, 1'b0);
    n = 0;
    while (!(mem_rd_en && mem_rd_addr == 5'd12) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scan_reached_12", 64'(mem_rd_addr), 64'd12);
    #2 rst_n = 1'b0;
    #1;
    chk("midscan_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midscan_rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    chk("midscan_rst_req_ready", 64'(req_ready), 64'd1);
    chk("midscan_rst_student", 64'(rsp_student), 64'd0);
    chk("midscan_rst_overtime", 64'(rsp_overtime), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Normal LOOKUP after reset
    e = mk(5'd3, 32'h1234_ABCD, 2'b01, 11'd50, 1'b1, 1'b0, 1);
    issue(1'b0, 5'd3, e, 2, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seat_status_reader.md
# seat_status_reader

Read-side responder for the seat record memory. Accepts seat queries over a valid/ready request channel, reads records through the memory's synchronous read port, and returns student number, seat state, elapsed time and an overtime flag. Also performs a first-free-seat scan. Sits beside the seat table as the counterpart of the write path; it never modifies records.

## Interface
- NUM_SEATS, 32, number of seat records
- SEAT_W, 5, seat index width
- TIME_W, 11, timer width, matching the free-running system timer
- STUDENT_W, 32, student number width
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE
- req_op  in  1  0 = LOOKUP, 1 = FIND_FREE
- req_seat  in  SEAT_W  seat to look up; ignored for FIND_FREE
- now_time  in  TIME_W  current timer value
- limit_time  in  TIME_W  configured limit time
- mem_rd_en  out  1  memory read strobe
- mem_rd_addr  out  SEAT_W  memory read address
- mem_rd_student  in  STUDENT_W  read data, valid the cycle after mem_rd_en
- mem_rd_state  in  2  read data: seat state
- mem_rd_stamp  in  TIME_W  read data: timestamp of last write
- rsp_valid  out  1  response present; held until accepted
- rsp_ready  in  1  consumer accepts response
- rsp_seat, rsp_student, rsp_state, rsp_elapsed  out  SEAT_W/STUDENT_W/2/TIME_W  response fields
- rsp_found  out  1  LOOKUP: seat not EMPTY; FIND_FREE: free seat located
- rsp_overtime  out  1  seat AWAY and elapsed > limit_time

## Operation
- Seat states: 00 EMPTY, 01 SEATED, 10 AWAY, 11 RESERVED.
- FSM states:
  - IDLE: req_valid & req_ready goes to READ (LOOKUP) or SCAN (FIND_FREE); the request is registered.
  - READ: one mem_rd_en at req_seat, then go to CHECK.
  - SCAN: pipelined; issues address k while checking data for k-1.
  - CHECK: computes response fields.
  - RESP: holds fields until rsp_ready, then returns to IDLE.
- elapsed = (now_time − mem_rd_stamp) mod 2^TIME_W, using now_time sampled in the data cycle. Wrap-around is legal and expected.
- EMPTY seat: rsp_elapsed = 0, rsp_overtime = 0. Overtime uses strict >, so elapsed == limit_time is not overtime.
- FIND_FREE:
  - Scans ascending from 0 and stops at the first EMPTY seat; rsp_seat is that index.
  - Once found, the in-flight read is discarded.
  - No free seat: rsp_found = 0, rsp_seat = NUM_SEATS−1, other fields from the last record.
- LOOKUP with req_seat ≥ NUM_SEATS: no memory read; response has found = 0 and all other fields 0, at normal latency.
- Response fields are registered and stable while rsp_valid = 1 and rsp_ready = 0.

## Timing
- Reset (async, immediate):
  - FSM to IDLE.
  - rsp_valid, mem_rd_en and all rsp_* fields 0; mem_rd_addr 0.
  - req_ready = 1.
  - A scan or pending response is abandoned with no response.
- Request accepted at edge E0:
  - mem_rd_en high in cycle E0–E1.
  - Data sampled at E1.
  - rsp_valid high from E2.
  - LOOKUP latency: 2 cycles.
- FIND_FREE:
  - First free seat k: rsp_valid from E(k+2).
  - No free seat: rsp_valid from E(NUM_SEATS+1).
  - mem_rd_en is continuous during the scan and never exceeds address NUM_SEATS−1.
- Response accepted (rsp_valid & rsp_ready) at edge En: rsp_valid low and req_ready high from En. The next request is accepted no earlier than En+1; no overlap of requests.
- req_ready is low from E0 until response acceptance.
- Memory read data is assumed to change only in response to mem_rd_en. Concurrent writes are outside this block; data read is returned as-is.

## Structure
- Shared package seat_pkg:
  - NUM_SEATS, SEAT_W, TIME_W, STUDENT_W.
  - seat_state_t enum (EMPTY/SEATED/AWAY/RESERVED).
  - req_op_t enum.
  - Shared with the write-path modules.
- One sub-module, seat_elapsed_calc: combinational modular subtraction plus overtime compare. It is reused by the write-path limit check.
- The FSM and scan counter (SEAT_W+1 bits) live in the top module.

## Test plan
- LOOKUP seat 3 holding {student 0x1234ABCD, SEATED, stamp 100}, now 150 → rsp_valid at E2; found = 1, elapsed = 50, overtime = 0.
- LOOKUP AWAY seat, stamp 2040, now 20, limit 20 → elapsed 28 (wrap), overtime = 1. Same with limit 28 → overtime = 0.
- FIND_FREE with seats 0–6 occupied and seat 7 EMPTY → rsp_seat = 7, found = 1, rsp_valid at E9. All seats occupied → found = 0, seat = 31, rsp_valid at E33.
- rsp_ready held low for 5 cycles → fields stable and req_ready = 0 throughout; new req_valid ignored until one cycle after acceptance.
- rst_n asserted mid-scan at seat 12 → rsp_valid and mem_rd_en drop immediately, req_ready = 1; a following LOOKUP behaves normally.
